axil_slave_regs: RTL and testbench

//  AXI4-Lite responder (slave) providing a bank of 32-bit control registers plus one read-only status word.

---
 rtl/axil_slave_regs.sv | 116 +++++++++++
 tb/tb_axil_slave_regs.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/axil_slave_regs.sv
// axil_slave_regs: AXI4-Lite responder with NUM_RW_REGS byte-writable control registers and one read-only status word
module axil_slave_regs #(
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_RW_REGS = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic [ADDR_WIDTH-1:0]      S_AXI_AWADDR,
    input  logic [3:0]                 S_AXI_AWCACHE,
    input  logic [2:0]                 S_AXI_AWPROT,
    input  logic                       S_AXI_AWVALID,
    output logic                       S_AXI_AWREADY,
    input  logic [31:0]                S_AXI_WDATA,
    input  logic [3:0]                 S_AXI_WSTRB,
    input  logic                       S_AXI_WVALID,
    output logic                       S_AXI_WREADY,
    output logic                       S_AXI_BVALID,
    input  logic                       S_AXI_BREADY,
    output logic [1:0]                 S_AXI_BRESP,
    input  logic [ADDR_WIDTH-1:0]      S_AXI_ARADDR,
    input  logic [3:0]                 S_AXI_ARCACHE,
    input  logic [2:0]                 S_AXI_ARPROT,
    input  logic                       S_AXI_ARVALID,
    output logic                       S_AXI_ARREADY,
    output logic [31:0]                S_AXI_RDATA,
    output logic [1:0]                 S_AXI_RRESP,
    output logic                       S_AXI_RVALID,
    input  logic                       S_AXI_RREADY,
    output logic [32*NUM_RW_REGS-1:0]  REG_OUT,
    output logic [NUM_RW_REGS-1:0]     WR_PULSE,
    input  logic [31:0]                STATUS_IN
);
    localparam int IW = ADDR_WIDTH - 2;
    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic rst_done, aw_done, w_done, aw_hs, w_hs, ar_hs;
    logic [IW-1:0] aw_idx, ar_idx;
    logic [31:0] wdata_q, ar_rdata;
    logic [3:0] wstrb_q;
    logic [31:0] regs [NUM_RW_REGS];
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_ARCACHE, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
    // rst_done keeps every READY low until the first edge after reset is released
    assign S_AXI_AWREADY = rst_done && w_state == W_IDLE && !aw_done;
    assign S_AXI_WREADY  = rst_done && w_state == W_IDLE && !w_done;
    assign S_AXI_ARREADY = rst_done && r_state == R_IDLE;
    assign S_AXI_BVALID  = w_state == W_RESP;
    assign S_AXI_RVALID  = r_state == R_DATA;
    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    for (genvar i = 0; i < NUM_RW_REGS; i++) begin : g_out
        assign REG_OUT[32*i+:32] = regs[i];
    end
    always_comb begin
        w_next = w_state;
        if (w_state == W_IDLE && (aw_done || aw_hs) && (w_done || w_hs)) w_next = W_COMMIT;
        if (w_state == W_COMMIT) w_next = W_RESP;
        if (w_state == W_RESP && S_AXI_BREADY) w_next = W_IDLE;
        r_next = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (S_AXI_RREADY ? R_IDLE : R_DATA);
        ar_rdata = ar_idx == IW'(NUM_RW_REGS) ? STATUS_IN : 32'h0;
        for (int i = 0; i < NUM_RW_REGS; i++)
            if (ar_idx == IW'(i)) ar_rdata = regs[i];
    end
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state     <= W_IDLE;
            r_state     <= R_IDLE;
            rst_done    <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            aw_idx      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            S_AXI_BRESP <= 2'b00;
            S_AXI_RRESP <= 2'b00;
            S_AXI_RDATA <= '0;
            WR_PULSE    <= '0;
            for (int i = 0; i < NUM_RW_REGS; i++) regs[i] <= '0;
        end else begin
            w_state  <= w_next;
            r_state  <= r_next;
            rst_done <= 1'b1;
            WR_PULSE <= '0;
            if (aw_hs) begin
                aw_done <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_done  <= 1'b1;
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (w_state == W_COMMIT) begin
                aw_done     <= 1'b0;
                w_done      <= 1'b0;
                S_AXI_BRESP <= aw_idx < IW'(NUM_RW_REGS) ? 2'b00 : 2'b10;
                for (int i = 0; i < NUM_RW_REGS; i++)
                    if (aw_idx == IW'(i)) begin
                        WR_PULSE[i] <= 1'b1;
                        for (int j = 0; j < 4; j++)
                            if (wstrb_q[j]) regs[i][8*j+:8] <= wdata_q[8*j+:8];
                    end
            end
            // regs are sampled before any same-edge commit lands, so reads see the old value
            if (ar_hs) begin
                S_AXI_RDATA <= ar_rdata;
                S_AXI_RRESP <= ar_idx <= IW'(NUM_RW_REGS) ? 2'b00 : 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_axil_slave_regs.sv
// tb_axil_slave_regs: directed AXI4-Lite register accesses with hand-computed expectations
module tb_axil_slave_regs;
    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic [31:0]  S_AXI_AWADDR = '0;
    logic [3:0]   S_AXI_AWCACHE = '0;
    logic [2:0]   S_AXI_AWPROT = '0;
    logic         S_AXI_AWVALID = 1'b0;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA = '0;
    logic [3:0]   S_AXI_WSTRB = '0;
    logic         S_AXI_WVALID = 1'b0;
    logic         S_AXI_WREADY;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY = 1'b0;
    logic [1:0]   S_AXI_BRESP;
    logic [31:0]  S_AXI_ARADDR = '0;
    logic [3:0]   S_AXI_ARCACHE = '0;
    logic [2:0]   S_AXI_ARPROT = '0;
    logic         S_AXI_ARVALID = 1'b0;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY = 1'b0;
    logic [127:0] REG_OUT;
    logic [3:0]   WR_PULSE;
    logic [31:0]  STATUS_IN = '0;
    int checks = 0;
    int errors = 0;
    logic [1:0]  resp;
    logic [3:0]  pulse;
    logic [31:0] rdata;

    axil_slave_regs #(.ADDR_WIDTH(32), .NUM_RW_REGS(4)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWCACHE(S_AXI_AWCACHE), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARCACHE(S_AXI_ARCACHE), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .REG_OUT(REG_OUT), .WR_PULSE(WR_PULSE), .STATUS_IN(STATUS_IN)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a negedge; inputs change and outputs are sampled only there.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input int hold, input bit do_resp,
                             output logic [1:0] bresp, output logic [3:0] wp);
        bit aw_pend = 1, w_pend = 1, a, w;
        int n = 0;
        int lat = 0;
        logic [1:0] first;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_WVALID  = 1'b1;
        S_AXI_AWVALID = (w_lead == 0);
        while ((aw_pend || w_pend) && n < 50) begin
            a = S_AXI_AWVALID && S_AXI_AWREADY;
            w = S_AXI_WVALID && S_AXI_WREADY;
            @(negedge ACLK);
            n++;
            if (a) begin S_AXI_AWVALID = 1'b0; aw_pend = 0; end
            if (w) begin S_AXI_WVALID = 1'b0; w_pend = 0; end
            if (aw_pend && n >= w_lead) S_AXI_AWVALID = 1'b1;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("wr_handshake_timeout", {126'b0, aw_pend, w_pend}, 128'h0);
        while (!S_AXI_BVALID && lat < 20) begin
            @(negedge ACLK);
            lat++;
        end
        check("bvalid_latency", lat, 1);
        bresp = S_AXI_BRESP;
        wp    = WR_PULSE;
        first = S_AXI_BRESP;
        for (int k = 0; k < hold; k++) begin
            @(negedge ACLK);
            check("bvalid_held", S_AXI_BVALID, 1);
            check("bresp_held", S_AXI_BRESP, first);
            check("awready_low_in_resp", S_AXI_AWREADY, 0);
        end
        if (do_resp) begin
            S_AXI_BREADY = 1'b1;
            @(negedge ACLK);
            S_AXI_BREADY = 1'b0;
            check("bvalid_single", S_AXI_BVALID, 0);
            check("wr_pulse_one_cycle", WR_PULSE, 0);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] rr);
        bit a = 0;
        int n = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        while (!a && n < 50) begin
            a = S_AXI_ARVALID && S_AXI_ARREADY;
            @(negedge ACLK);
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        check("rvalid_after_ar", S_AXI_RVALID, 1);
        data = S_AXI_RDATA;
        rr   = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
        check("rvalid_drop", S_AXI_RVALID, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge ACLK);
        check("rst_awready", S_AXI_AWREADY, 0);
        check("rst_wready", S_AXI_WREADY, 0);
        check("rst_arready", S_AXI_ARREADY, 0);
        check("rst_bvalid", S_AXI_BVALID, 0);
        check("rst_rvalid", S_AXI_RVALID, 0);
        check("rst_reg_out", REG_OUT, 0);
        check("rst_wr_pulse", WR_PULSE, 0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("ready_after_rst", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        axi_write(32'h0, 32'h12345678, 4'b1111, 0, 0, 1, resp, pulse);
        check("t1_bresp", resp, 2'b00);
        check("t1_pulse", pulse, 4'b0001);
        check("t1_reg0", REG_OUT[31:0], 32'h12345678);
        axi_read(32'h0, rdata, resp);
        check("t1_rdata", rdata, 32'h12345678);
        check("t1_rresp", resp, 2'b00);

        axi_write(32'h4, 32'hFFFFFFFF, 4'b1111, 0, 0, 1, resp, pulse);
        axi_write(32'h4, 32'h00000000, 4'b0101, 0, 0, 1, resp, pulse);
        check("t2_pulse", pulse, 4'b0010);
        check("t2_reg1", REG_OUT[63:32], 32'hFF00FF00);

        axi_write(32'h8, 32'hA5A5A5A5, 4'b1111, 3, 0, 1, resp, pulse);
        check("t3_lead_bresp", resp, 2'b00);
        check("t3_lead_reg2", REG_OUT[95:64], 32'hA5A5A5A5);
        axi_write(32'hE, 32'h0BADBEEF, 4'b1111, 0, 0, 1, resp, pulse);
        check("t3_same_pulse", pulse, 4'b1000);
        check("t3_same_reg3", REG_OUT[127:96], 32'h0BADBEEF);

        axi_write(32'h1C, 32'hDEADBEEF, 4'b1111, 0, 0, 1, resp, pulse);
        check("t4_bresp", resp, 2'b10);
        check("t4_pulse", pulse, 4'b0000);
        check("t4_reg_out", REG_OUT, 128'h0BADBEEF_A5A5A5A5_FF00FF00_12345678);
        axi_read(32'h1C, rdata, resp);
        check("t4_rdata", rdata, 32'h0);
        check("t4_rresp", resp, 2'b10);

        STATUS_IN = 32'hCAFEF00D;
        axi_read(32'h10, rdata, resp);
        check("t5_status", rdata, 32'hCAFEF00D);
        check("t5_rresp", resp, 2'b00);
        axi_write(32'h10, 32'h11111111, 4'b1111, 0, 0, 1, resp, pulse);
        check("t5_bresp", resp, 2'b10);
        check("t5_reg_out", REG_OUT, 128'h0BADBEEF_A5A5A5A5_FF00FF00_12345678);

        axi_write(32'h8, 32'h77777777, 4'b0000, 0, 0, 1, resp, pulse);
        check("strb0_bresp", resp, 2'b00);
        check("strb0_pulse", pulse, 4'b0100);
        check("strb0_reg2", REG_OUT[95:64], 32'hA5A5A5A5);

        axi_write(32'h0, 32'h00C0FFEE, 4'b0011, 0, 5, 1, resp, pulse);
        check("t6_bresp", resp, 2'b00);
        check("t6_reg0", REG_OUT[31:0], 32'h1234FFEE);

        axi_write(32'h4, 32'h55555555, 4'b1111, 0, 2, 0, resp, pulse);
        check("t6_reg1_before_rst", REG_OUT[63:32], 32'h55555555);
        ARESETN = 1'b0;
        @(negedge ACLK);
        check("t6_rst_bvalid", S_AXI_BVALID, 0);
        check("t6_rst_reg_out", REG_OUT, 0);
        check("t6_rst_awready", S_AXI_AWREADY, 0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("t6_ready_again", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID}, 4'b1110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
